// File: rtl/packet_receiver_pkg.sv
// packet_receiver_pkg: shared state encoding, default framing bytes and a width helper.
package packet_receiver_pkg;

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, FOOTER} state_t;

   localparam logic [7:0] DEF_HEADER = 8'h2A;
   localparam logic [7:0] DEF_FOOTER = 8'h2A;

   // $clog2 that never returns less than 1, so counters always have a bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/packet_receiver_rx_timeout_counter.sv
// packet_receiver_rx_timeout_counter: inter-byte idle timer.
//   clk, rst (async, active-low)
//   clear   : a byte arrived; restart the idle count
//   run     : a frame is in progress; count idle cycles
//   limit   : idle clocks allowed after a byte
//   expired : limit reached while running
module packet_receiver_rx_timeout_counter #(
   parameter int LIMIT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               run,
   input  logic [LIMIT_W-1:0] limit,
   output logic               expired
);

   logic [LIMIT_W-1:0] cnt;

   // The byte edge loads 1, so after the n-th following edge cnt equals n
   // and the error lands exactly limit clocks after the last byte.
   assign expired = run && (cnt == limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else if (clear) cnt <= LIMIT_W'(1);
      else if (!run) cnt <= '0;
      else if (!expired) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: framed byte-stream receiver committing good payloads to a valid/ack bus.
//   clk, rst (async, active-low)
//   rx_data, rx_new  : byte stream from the UART receiver
//   words            : committed payload, word k at [k*WORD_W +: WORD_W], LS byte first on the wire
//   frame_valid      : committed payload not yet acknowledged
//   frame_ack        : consumer accepts the current frame
//   frame_err        : 1-cycle pulse on bad footer, bad checksum or timeout
//   overrun          : 1-cycle pulse when a good frame is dropped because the last is unacked
// Build option: define CKSUM_EN to require an XOR check byte between payload and footer.
module packet_receiver
   import packet_receiver_pkg::*;
#(
   parameter int         WORD_W      = 64,
   parameter int         NUM_WORDS   = 2,
   parameter logic [7:0] HEADER_BYTE = DEF_HEADER,
   parameter logic [7:0] FOOTER_BYTE = DEF_FOOTER,
   parameter int         TIMEOUT_CYC = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_new,
   output logic [NUM_WORDS*WORD_W-1:0]   words,
   output logic                          frame_valid,
   input  logic                          frame_ack,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int W      = NUM_WORDS * WORD_W;
   localparam int NBYTES = W / 8;
   localparam int CNT_W  = clog2_min1(NBYTES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     shadow;
   logic             timed_out;
`ifdef CKSUM_EN
   logic [7:0]       cksum;
`endif

   generate
      if (TIMEOUT_CYC > 0) begin : g_to
         localparam int TW = clog2_min1(TIMEOUT_CYC + 1);
         packet_receiver_rx_timeout_counter #(.LIMIT_W(TW)) u_to (
            .clk     (clk),
            .rst     (rst),
            .clear   (rx_new),
            .run     (state != IDLE),
            .limit   (TW'(TIMEOUT_CYC)),
            .expired (timed_out)
         );
      end else begin : g_no_to
         assign timed_out = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shadow      <= '0;
         words       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
`ifdef CKSUM_EN
         cksum       <= '0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // A commit later in this block overrides the clear, so ack and a new
         // frame on the same edge leave frame_valid high with the new payload.
         if (frame_valid && frame_ack) frame_valid <= 1'b0;
         if (rx_new) begin
            case (state)
               IDLE: if (rx_data == HEADER_BYTE) begin
                  state <= PAYLOAD;
                  cnt   <= '0;
`ifdef CKSUM_EN
                  cksum <= '0;
`endif
               end
               PAYLOAD: begin
                  shadow[{cnt, 3'b000} +: 8] <= rx_data;
                  cnt <= cnt + 1'b1;
`ifdef CKSUM_EN
                  cksum <= cksum ^ rx_data;
                  if (cnt == LAST) state <= CHECK;
`else
                  if (cnt == LAST) state <= FOOTER;
`endif
               end
`ifdef CKSUM_EN
               CHECK: begin
                  state     <= (rx_data == cksum) ? FOOTER : IDLE;
                  frame_err <= rx_data != cksum;
               end
`endif
               FOOTER: begin
                  state <= IDLE;
                  if (rx_data != FOOTER_BYTE) frame_err <= 1'b1;
                  else if (frame_valid && !frame_ack) overrun <= 1'b1;
                  else begin
                     words       <= shadow;
                     frame_valid <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (timed_out) begin
            frame_err <= 1'b1;
            state     <= IDLE;
         end
      end
   end

endmodule
